// File: rtl/servo_lock_sequencer.sv
// Lock-acquisition controller for the laser servo chain: gates sweep and PID,
// qualifies lock with a hysteretic threshold, a settle window and loss debounce.
module servo_lock_sequencer #(
   parameter int W               = 16,
   parameter int SETTLE_CYCLES   = 1000,
   parameter int LOSS_DEBOUNCE   = 16,
   parameter int LED_HOLD_CYCLES = 100000000,
   parameter int CNT_W           = 28
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          enable_in,
   input  logic [W-1:0]  trans_in,
   input  logic [W-1:0]  minval_in,
   input  logic [W-1:0]  hyst_in,
   input  logic          param_update_in,
   output logic          sweep_hold_out,
   output logic          pid_on_out,
   output logic          pid_clear_out,
   output logic          locked_out,
   output logic          notlocked_out,
   output logic          notlocked1s_out,
   output logic [2:0]    state_out,
   output logic [15:0]   relock_count_out
);

   localparam int LW = (LOSS_DEBOUNCE > 1) ? $clog2(LOSS_DEBOUNCE) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SWEEP  = 3'd1,
      S_ACQ    = 3'd2,
      S_LOCKED = 3'd3
   } state_t;

   state_t             state_q, state_d;
   logic               below_q, above_q;
   logic               below_d, above_d;
   logic [LW-1:0]      loss_cnt_q, loss_cnt_d;
   logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
   logic [CNT_W-1:0]   led_cnt_q, led_cnt_d;
   logic [15:0]        relock_cnt_q, relock_cnt_d;
   logic               hold_q, hold_d;
   logic               pid_on_q, pid_on_d;
   logic               pid_clear_q, pid_clear_d;
   logic               locked_n_q, locked_n_d;
   logic               notlocked_n_q, notlocked_n_d;
   logic               notlocked1s_n_q, notlocked1s_n_d;

   logic               loss, settle_done, reenter, clear_pulse, lock_evt, entry;
   logic signed [W:0]  acq_thr, trans_ext;

   // Acquire threshold is formed one bit wider so minval + hyst never wraps.
   assign acq_thr   = $signed({minval_in[W-1], minval_in}) + $signed({1'b0, hyst_in});
   assign trans_ext = $signed({trans_in[W-1], trans_in});
   assign below_d   = $signed(trans_in) < $signed(minval_in);
   assign above_d   = trans_ext >= acq_thr;

   assign loss        = below_q && (loss_cnt_q == LW'(LOSS_DEBOUNCE - 1));
   assign settle_done = (settle_cnt_q == CNT_W'(SETTLE_CYCLES - 1));

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q         <= S_IDLE;
         below_q         <= 1'b0;
         above_q         <= 1'b0;
         loss_cnt_q      <= '0;
         settle_cnt_q    <= '0;
         led_cnt_q       <= '0;
         relock_cnt_q    <= '0;
         hold_q          <= 1'b1;
         pid_on_q        <= 1'b0;
         pid_clear_q     <= 1'b0;
         locked_n_q      <= 1'b1;
         notlocked_n_q   <= 1'b1;
         notlocked1s_n_q <= 1'b1;
      end else begin
         state_q         <= state_d;
         below_q         <= below_d;
         above_q         <= above_d;
         loss_cnt_q      <= loss_cnt_d;
         settle_cnt_q    <= settle_cnt_d;
         led_cnt_q       <= led_cnt_d;
         relock_cnt_q    <= relock_cnt_d;
         hold_q          <= hold_d;
         pid_on_q        <= pid_on_d;
         pid_clear_q     <= pid_clear_d;
         locked_n_q      <= locked_n_d;
         notlocked_n_q   <= notlocked_n_d;
         notlocked1s_n_q <= notlocked1s_n_d;
      end
   end

   // Priority: disable > coefficient update > loss > settle done.
   always_comb begin
      state_d     = state_q;
      reenter     = 1'b0;
      clear_pulse = 1'b0;
      lock_evt    = 1'b0;
      if (!enable_in) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_SWEEP;
            S_SWEEP: begin
               if (above_q) begin
                  state_d     = S_ACQ;
                  clear_pulse = 1'b1;
               end
            end
            S_ACQ: begin
               if (param_update_in) begin
                  reenter     = 1'b1;
                  clear_pulse = 1'b1;
               end else if (loss) begin
                  state_d = S_SWEEP;
               end else if (settle_done) begin
                  state_d  = S_LOCKED;
                  lock_evt = 1'b1;
               end
            end
            S_LOCKED: begin
               if (param_update_in) begin
                  state_d     = S_ACQ;
                  clear_pulse = 1'b1;
               end else if (loss) begin
                  state_d = S_SWEEP;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      entry = (state_d != state_q) || reenter;
   end

   always_comb begin
      loss_cnt_d   = loss_cnt_q;
      settle_cnt_d = '0;
      led_cnt_d    = '0;
      relock_cnt_d = relock_cnt_q;
      if (entry || !below_q)
         loss_cnt_d = '0;
      else if (loss_cnt_q != LW'(LOSS_DEBOUNCE - 1))
         loss_cnt_d = loss_cnt_q + 1'b1;
      if (!entry && state_q == S_ACQ)
         settle_cnt_d = settle_cnt_q + 1'b1;
      // The LED timer is live only while LOCKED and reloads on every entry.
      if (state_d == S_LOCKED) begin
         if (state_q != S_LOCKED)
            led_cnt_d = CNT_W'(LED_HOLD_CYCLES);
         else if (led_cnt_q != '0)
            led_cnt_d = led_cnt_q - 1'b1;
      end
      if (lock_evt && relock_cnt_q != 16'hFFFF)
         relock_cnt_d = relock_cnt_q + 16'd1;
   end

   always_comb begin
      hold_d          = (state_d != S_SWEEP);
      pid_on_d        = (state_d == S_ACQ) || (state_d == S_LOCKED);
      pid_clear_d     = clear_pulse;
      locked_n_d      = (state_d != S_LOCKED);
      notlocked_n_d   = !((state_d == S_SWEEP) || (state_d == S_ACQ));
      notlocked1s_n_d = !((state_d == S_ACQ) || ((state_d == S_LOCKED) && (led_cnt_d != '0)));
   end

   assign sweep_hold_out   = hold_q;
   assign pid_on_out       = pid_on_q;
   assign pid_clear_out    = pid_clear_q;
   assign locked_out       = locked_n_q;
   assign notlocked_out    = notlocked_n_q;
   assign notlocked1s_out  = notlocked1s_n_q;
   assign state_out        = state_q;
   assign relock_count_out = relock_cnt_q;

endmodule

// File: tb/tb_servo_lock_sequencer.sv
// Directed bench for servo_lock_sequencer; each step queues the expected output
// word and compares it against the DUT one edge later.
module tb_servo_lock_sequencer;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SWEEP  = 3'd1;
   localparam logic [2:0] ST_ACQ    = 3'd2;
   localparam logic [2:0] ST_LOCKED = 3'd3;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        enable_in;
   logic [15:0] trans_in;
   logic [15:0] minval_in;
   logic [15:0] hyst_in;
   logic        param_update_in;
   logic        sweep_hold_out, pid_on_out, pid_clear_out;
   logic        locked_out, notlocked_out, notlocked1s_out;
   logic [2:0]  state_out;
   logic [15:0] relock_count_out;

   typedef struct packed {
      logic [2:0]  st;
      logic        hold;
      logic        pid_on;
      logic        clr;
      logic        lk_n;
      logic        nl_n;
      logic        nl1s_n;
      logic [15:0] cnt;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   servo_lock_sequencer #(
      .W(16), .SETTLE_CYCLES(8), .LOSS_DEBOUNCE(4), .LED_HOLD_CYCLES(20), .CNT_W(28)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .trans_in(trans_in),
      .minval_in(minval_in), .hyst_in(hyst_in), .param_update_in(param_update_in),
      .sweep_hold_out(sweep_hold_out), .pid_on_out(pid_on_out), .pid_clear_out(pid_clear_out),
      .locked_out(locked_out), .notlocked_out(notlocked_out), .notlocked1s_out(notlocked1s_out),
      .state_out(state_out), .relock_count_out(relock_count_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic obs_t mk(input logic [2:0] st, input logic clr, input logic n1s,
                               input logic [15:0] cnt);
      obs_t e;
      e.st     = st;
      e.hold   = (st != ST_SWEEP);
      e.pid_on = (st == ST_ACQ) || (st == ST_LOCKED);
      e.clr    = clr;
      e.lk_n   = (st != ST_LOCKED);
      e.nl_n   = !((st == ST_SWEEP) || (st == ST_ACQ));
      e.nl1s_n = n1s;
      e.cnt    = cnt;
      return e;
   endfunction

   function automatic obs_t observed();
      obs_t o;
      o.st     = state_out;
      o.hold   = sweep_hold_out;
      o.pid_on = pid_on_out;
      o.clr    = pid_clear_out;
      o.lk_n   = locked_out;
      o.nl_n   = notlocked_out;
      o.nl1s_n = notlocked1s_out;
      o.cnt    = relock_count_out;
      return o;
   endfunction

   task automatic check(input string tag);
      obs_t o, e;
      o = observed();
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s observed=%h expected=<scoreboard empty>", tag, o);
      end else begin
         e = exp_q.pop_front();
         assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
         end
         $display("%-22s st=%0d clr=%0b n1s=%0b cnt=%0d", tag, o.st, o.clr, o.nl1s_n, o.cnt);
      end
   endtask

   task automatic run(input int n, input logic [15:0] tr, input logic en, input logic pu_v,
                      input logic [2:0] st, input logic clr, input logic n1s,
                      input logic [15:0] cnt, input string tag);
      for (int i = 0; i < n; i++) begin
         trans_in        = tr;
         enable_in       = en;
         param_update_in = pu_v;
         exp_q.push_back(mk(st, clr, n1s, cnt));
         @(posedge clk_in);
         #1;
         check(tag);
      end
   endtask

   initial begin
      rst_in          = 1'b1;
      enable_in       = 1'b1;
      trans_in        = 16'h1000;
      minval_in       = 16'h2000;
      hyst_in         = 16'h0400;
      param_update_in = 1'b0;
      #1;
      exp_q.push_back(mk(ST_IDLE, 1'b0, 1'b1, 16'd0));
      check("reset_async");
      repeat (2) @(posedge clk_in);
      #1;
      exp_q.push_back(mk(ST_IDLE, 1'b0, 1'b1, 16'd0));
      check("reset_held");
      rst_in = 1'b0;

      // 1: enable after reset goes to SWEEP
      run(1, 16'h1000, 1, 0, ST_SWEEP, 0, 1, 16'd0, "t1_sweep");
      run(3, 16'h1000, 1, 0, ST_SWEEP, 0, 1, 16'd0, "t1_sweep_stay");
      // 2: acquire, settle, lock, LED hold window
      run(1, 16'h3000, 1, 0, ST_SWEEP,  0, 1, 16'd0, "t2_step_seen");
      run(1, 16'h3000, 1, 0, ST_ACQ,    1, 0, 16'd0, "t2_acq_entry");
      run(7, 16'h3000, 1, 0, ST_ACQ,    0, 0, 16'd0, "t2_settle");
      run(1, 16'h3000, 1, 0, ST_LOCKED, 0, 0, 16'd1, "t2_lock");
      run(19, 16'h3000, 1, 0, ST_LOCKED, 0, 0, 16'd1, "t2_led_on");
      run(3, 16'h3000, 1, 0, ST_LOCKED, 0, 1, 16'd1, "t2_led_off");
      // 3: loss debounce
      run(3, 16'h1F00, 1, 0, ST_LOCKED, 0, 1, 16'd1, "t3_three_below");
      run(3, 16'h2100, 1, 0, ST_LOCKED, 0, 1, 16'd1, "t3_recover");
      run(6, 16'h2000, 1, 0, ST_LOCKED, 0, 1, 16'd1, "t3_at_minval");
      run(4, 16'h1F00, 1, 0, ST_LOCKED, 0, 1, 16'd1, "t3_debounce");
      run(1, 16'h2200, 1, 0, ST_SWEEP,  0, 1, 16'd1, "t3_loss");
      // 4: hysteresis band, update ignored in SWEEP, exact acquire threshold
      run(10, 16'h2200, 1, 0, ST_SWEEP, 0, 1, 16'd1, "t4_band");
      run(1, 16'h2200, 1, 1, ST_SWEEP,  0, 1, 16'd1, "t4_pu_ignored");
      run(1, 16'h2400, 1, 0, ST_SWEEP,  0, 1, 16'd1, "t4_thresh_seen");
      run(1, 16'h2400, 1, 0, ST_ACQ,    1, 0, 16'd1, "t4_acq_entry");
      run(7, 16'h2400, 1, 0, ST_ACQ,    0, 0, 16'd1, "t4_settle");
      run(1, 16'h2400, 1, 0, ST_LOCKED, 0, 0, 16'd2, "t4_lock");
      run(3, 16'h2400, 1, 0, ST_LOCKED, 0, 0, 16'd2, "t4_locked");
      // 5: coefficient update re-settles; update on settle-done blocks lock
      run(1, 16'h2400, 1, 1, ST_ACQ,    1, 0, 16'd2, "t5_pu_locked");
      run(7, 16'h2400, 1, 0, ST_ACQ,    0, 0, 16'd2, "t5_settle");
      run(1, 16'h2400, 1, 0, ST_LOCKED, 0, 0, 16'd3, "t5_relock");
      run(2, 16'h2400, 1, 0, ST_LOCKED, 0, 0, 16'd3, "t5_locked");
      run(1, 16'h2400, 1, 1, ST_ACQ,    1, 0, 16'd3, "t5_pu_again");
      run(7, 16'h2400, 1, 0, ST_ACQ,    0, 0, 16'd3, "t5_settle2");
      run(1, 16'h2400, 1, 1, ST_ACQ,    1, 0, 16'd3, "t5_pu_settle_done");
      run(7, 16'h2400, 1, 0, ST_ACQ,    0, 0, 16'd3, "t5_settle3");
      run(1, 16'h2400, 1, 0, ST_LOCKED, 0, 0, 16'd4, "t5_relock2");
      run(2, 16'h2400, 1, 0, ST_LOCKED, 0, 0, 16'd4, "t5_locked2");
      // 6: disable from ACQUIRE, then async reset mid-LOCKED
      run(1, 16'h2400, 1, 1, ST_ACQ,    1, 0, 16'd4, "t6_pu");
      run(2, 16'h2400, 1, 0, ST_ACQ,    0, 0, 16'd4, "t6_acq");
      run(1, 16'h2400, 0, 0, ST_IDLE,   0, 1, 16'd4, "t6_disable");
      run(1, 16'h2400, 0, 0, ST_IDLE,   0, 1, 16'd4, "t6_idle");
      run(1, 16'h2400, 1, 0, ST_SWEEP,  0, 1, 16'd4, "t6_reenable");
      run(1, 16'h2400, 1, 0, ST_ACQ,    1, 0, 16'd4, "t6_acq_entry");
      run(7, 16'h2400, 1, 0, ST_ACQ,    0, 0, 16'd4, "t6_settle");
      run(1, 16'h2400, 1, 0, ST_LOCKED, 0, 0, 16'd5, "t6_lock");
      run(2, 16'h2400, 1, 0, ST_LOCKED, 0, 0, 16'd5, "t6_locked");
      #3 rst_in = 1'b1;
      #1;
      exp_q.push_back(mk(ST_IDLE, 1'b0, 1'b1, 16'd0));
      check("t6_async_rst");
      @(posedge clk_in);
      #1;
      exp_q.push_back(mk(ST_IDLE, 1'b0, 1'b1, 16'd0));
      check("t6_rst_held");
      rst_in = 1'b0;
      run(1, 16'h2400, 1, 0, ST_SWEEP, 0, 1, 16'd0, "t6_after_rst");
      run(1, 16'h2400, 1, 0, ST_ACQ,   1, 0, 16'd0, "t6_acq_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
